br_pred_unit: RTL and testbench

- Parametrised successor to the execute-stage branch resolver.
- Adds a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters, queried combinationally at fetch.
- Resolves branches/jumps in execute from true operand values and updates the BTB.
- Issues a registered redirect (one cycle after resolve) when the fetch-time prediction was wrong.

---
 rtl/br_pred_unit.sv | 175 +++++++++++++++++
 tb/tb_br_pred_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/br_pred_unit.sv
// Branch predictor / resolver: direct-mapped BTB with saturating direction
// counters looked up at fetch, branch resolution in execute, and a registered
// one-cycle redirect on mispredict.
// Optional: define BR_PRED_STATS_EN to add branch / mispredict counters.
module br_pred_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned CNT_BITS    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_pc,
    input  logic            ex_valid,
    input  logic            ex_br,
    input  logic [2:0]      ex_br_op,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_pred_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            misalign
`ifdef BR_PRED_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX - 2;

    localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_WT   = CNT_BITS'(1 << (CNT_BITS - 1));
    localparam logic [CNT_BITS-1:0] CNT_WNT  = CNT_WT - CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;

    localparam logic [2:0] OP_BEQ  = 3'd0;
    localparam logic [2:0] OP_BNE  = 3'd1;
    localparam logic [2:0] OP_BLT  = 3'd2;
    localparam logic [2:0] OP_BGE  = 3'd3;
    localparam logic [2:0] OP_BLTU = 3'd4;
    localparam logic [2:0] OP_BGEU = 3'd5;
    localparam logic [2:0] OP_JALR = 3'd7;

    // BTB storage
    logic                valid_q  [BTB_ENTRIES];
    logic [TAG_W-1:0]    tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]     target_q [BTB_ENTRIES];
    logic [CNT_BITS-1:0] cnt_q    [BTB_ENTRIES];

    logic [IDX-1:0]      fetch_idx;
    logic [TAG_W-1:0]    fetch_tag;
    logic                fetch_hit;

    logic [IDX-1:0]      ex_idx;
    logic [TAG_W-1:0]    ex_tag;
    logic                ex_hit;
    logic                ex_jump;
    logic                cond;
    logic                taken;
    logic [XLEN-1:0]     br_target;
    logic [XLEN-1:0]     jalr_sum;
    logic [XLEN-1:0]     target;
    logic [XLEN-1:0]     actual_pc;
    logic                mispredict;
    logic                update;
    logic [CNT_BITS-1:0] cnt_cur;
    logic [CNT_BITS-1:0] cnt_next;

    // Fetch-time lookup on current table state
    always_comb begin
        fetch_idx  = fetch_pc[IDX+1:2];
        fetch_tag  = fetch_pc[XLEN-1:IDX+2];
        fetch_hit  = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        pred_taken = fetch_hit && cnt_q[fetch_idx][CNT_BITS-1];
        pred_pc    = pred_taken ? target_q[fetch_idx] : fetch_pc + XLEN'(4);
    end

    // Execute-stage resolution from true operand values
    always_comb begin
        cond = 1'b1;
        case (ex_br_op)
            OP_BEQ:  cond = (ex_rs1 == ex_rs2);
            OP_BNE:  cond = (ex_rs1 != ex_rs2);
            OP_BLT:  cond = ($signed(ex_rs1) <  $signed(ex_rs2));
            OP_BGE:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
            OP_BLTU: cond = (ex_rs1 <  ex_rs2);
            OP_BGEU: cond = (ex_rs1 >= ex_rs2);
            default: cond = 1'b1;
        endcase
        ex_jump    = ex_br_op[2] & ex_br_op[1];
        taken      = ex_br & cond;
        pc_plus4   = ex_pc + XLEN'(4);
        br_target  = ex_pc + ex_imm;
        jalr_sum   = ex_rs1 + ex_imm;
        target     = (ex_br_op == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : br_target;
        actual_pc  = taken ? target : pc_plus4;
        mispredict = ex_valid && (actual_pc != ex_pred_pc);
    end

    // Next direction counter for the entry addressed by ex_pc
    always_comb begin
        ex_idx   = ex_pc[IDX+1:2];
        ex_tag   = ex_pc[XLEN-1:IDX+2];
        ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        update   = ex_valid & ex_br;
        cnt_cur  = cnt_q[ex_idx];
        cnt_next = cnt_cur;
        if (ex_jump) begin
            cnt_next = CNT_MAX;
        end else if (taken) begin
            cnt_next = (cnt_cur == CNT_MAX) ? CNT_MAX : cnt_cur + CNT_BITS'(1);
        end else begin
            cnt_next = (cnt_cur == CNT_ZERO) ? CNT_ZERO : cnt_cur - CNT_BITS'(1);
        end
    end

    // BTB training: update on hit, allocate on taken miss
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_WNT;
            end
        end else if (update) begin
            if (ex_hit) begin
                cnt_q[ex_idx] <= cnt_next;
                if (taken) begin
                    target_q[ex_idx] <= target;
                end
            end else if (taken) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= target;
                cnt_q[ex_idx]    <= ex_jump ? CNT_MAX : CNT_WT;
            end
        end
    end

    // Registered redirect, one cycle after resolve
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            misalign       <= 1'b0;
        end else begin
            redirect_valid <= mispredict;
            redirect_pc    <= actual_pc;
            misalign       <= ex_valid & taken & target[1];
        end
    end

`ifdef BR_PRED_STATS_EN
    // Branch and mispredict event counters, wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (update) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_br_pred_unit.sv
// Scoreboard bench for br_pred_unit: directed resolves push expected redirects,
// a monitor pops and compares one cycle later.
module tb_br_pred_unit;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        ex_valid;
    logic        ex_br;
    logic [2:0]  ex_br_op;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic [31:0] ex_pred_pc;
    logic [31:0] pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        m;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    br_pred_unit dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_pc       (fetch_pc),
        .pred_taken     (pred_taken),
        .pred_pc        (pred_pc),
        .ex_valid       (ex_valid),
        .ex_br          (ex_br),
        .ex_br_op       (ex_br_op),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_pred_pc     (ex_pred_pc),
        .pc_plus4       (pc_plus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign       (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every resolve cycle out of reset yields one registered response
    always @(posedge clk) begin
        logic samp;
        exp_t e;
        samp = ex_valid && !rst;
        #1;
        if (samp) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard: response with empty queue");
            end else begin
                e = exp_q.pop_front();
                chk("redirect_valid", 32'(redirect_valid), 32'(e.v));
                chk("redirect_pc", redirect_pc, e.pc);
                chk("misalign", 32'(misalign), 32'(e.m));
            end
        end
    end

    task automatic resolve(input logic br, input logic [2:0] op, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [31:0] pred,
                           input logic ev, input logic [31:0] epc, input logic em);
        exp_t e;
        @(negedge clk);
        ex_valid   = 1'b1;
        ex_br      = br;
        ex_br_op   = op;
        ex_pc      = pc;
        ex_imm     = imm;
        ex_rs1     = rs1;
        ex_rs2     = rs2;
        ex_pred_pc = pred;
        e.v = ev;
        e.pc = epc;
        e.m = em;
        exp_q.push_back(e);
        #1;
        chk("pc_plus4", pc_plus4, pc + 32'd4);
    endtask

    task automatic lookup(input logic [31:0] pc, input logic et, input logic [31:0] epc);
        @(negedge clk);
        ex_valid = 1'b0;
        ex_br    = 1'b0;
        fetch_pc = pc;
        #1;
        chk("pred_taken", 32'(pred_taken), 32'(et));
        chk("pred_pc", pred_pc, epc);
    endtask

    initial begin
        rst = 1'b1;
        fetch_pc = '0; ex_valid = 1'b0; ex_br = 1'b0; ex_br_op = '0;
        ex_pc = '0; ex_imm = '0; ex_rs1 = '0; ex_rs2 = '0; ex_pred_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset redirect_valid", 32'(redirect_valid), 32'd0);
        chk("reset redirect_pc", redirect_pc, 32'd0);
        chk("reset misalign", 32'(misalign), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Empty BTB, first taken BEQ allocates weakly taken
        lookup(32'h100, 1'b0, 32'h104);
        resolve(1, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 32'h104, 1, 32'h120, 0);
        lookup(32'h100, 1'b1, 32'h120);
        resolve(1, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 32'h120, 0, 32'h120, 0);
        // Unsigned vs signed compare of -1 and 1
        resolve(1, 3'd4, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 32'h120, 1, 32'h104, 0);
        resolve(1, 3'd2, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 32'h120, 0, 32'h120, 0);
        // Saturate high
        for (int i = 0; i < 3; i++)
            resolve(1, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 32'h120, 0, 32'h120, 0);
        lookup(32'h100, 1'b1, 32'h120);
        resolve(1, 3'd1, 32'h100, 32'h20, 32'd5, 32'd5, 32'h120, 1, 32'h104, 0);
        lookup(32'h100, 1'b1, 32'h120);
        resolve(1, 3'd1, 32'h100, 32'h20, 32'd5, 32'd5, 32'h120, 1, 32'h104, 0);
        lookup(32'h100, 1'b0, 32'h104);
        // Saturate low
        resolve(1, 3'd1, 32'h100, 32'h20, 32'd5, 32'd5, 32'h120, 1, 32'h104, 0);
        resolve(1, 3'd1, 32'h100, 32'h20, 32'd5, 32'd5, 32'h120, 1, 32'h104, 0);
        lookup(32'h100, 1'b0, 32'h104);
        resolve(1, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 32'h104, 1, 32'h120, 0);
        lookup(32'h100, 1'b0, 32'h104);
        resolve(1, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 32'h104, 1, 32'h120, 0);
        lookup(32'h100, 1'b1, 32'h120);

        // JALR with misaligned target; 0x40 shares index 0 with 0x100
        resolve(1, 3'd7, 32'h40, 32'h0, 32'h2003, 32'd0, 32'h44, 1, 32'h2002, 1);
        lookup(32'h40, 1'b1, 32'h2002);
        lookup(32'h100, 1'b0, 32'h104);

        // Aliasing pair 0x100 / 0x140
        resolve(1, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 32'h104, 1, 32'h120, 0);
        lookup(32'h100, 1'b1, 32'h120);
        resolve(1, 3'd6, 32'h140, 32'h10, 32'd0, 32'd0, 32'h144, 1, 32'h150, 0);
        lookup(32'h140, 1'b1, 32'h150);
        lookup(32'h100, 1'b0, 32'h104);

        // JAL misaligned, unsigned/signed GE, non-branch
        resolve(1, 3'd6, 32'h84, 32'h6, 32'd0, 32'd0, 32'h88, 1, 32'h8A, 1);
        resolve(1, 3'd5, 32'h88, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h8C, 1, 32'h188, 0);
        resolve(1, 3'd3, 32'h88, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h8C, 0, 32'h8C, 0);
        resolve(0, 3'd0, 32'h200, 32'h40, 32'd5, 32'd5, 32'h204, 0, 32'h204, 0);
        resolve(0, 3'd0, 32'h200, 32'h40, 32'd5, 32'd5, 32'h300, 1, 32'h204, 0);
        lookup(32'h200, 1'b0, 32'h204);

        // Reset immediately after a mispredict, with a resolve in the reset cycle
        resolve(1, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 32'h104, 1, 32'h120, 0);
        @(negedge clk);
        rst        = 1'b1;
        ex_valid   = 1'b1;
        ex_br      = 1'b1;
        ex_br_op   = 3'd6;
        ex_pc      = 32'h10;
        ex_imm     = 32'h32;
        ex_pred_pc = 32'h14;
        @(posedge clk);
        #1;
        chk("rst redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst redirect_pc", redirect_pc, 32'd0);
        chk("rst misalign", 32'(misalign), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ex_valid = 1'b0;
        lookup(32'h100, 1'b0, 32'h104);
        lookup(32'h10, 1'b0, 32'h14);
        lookup(32'h84, 1'b0, 32'h88);

        // Drain scoreboard with a bound
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d responses still pending, expected 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
